// File: rtl/dmem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : dmem_pkg
// Brief  : Shared constants for the banked data memory: FSM state encoding,
//          legal read-latency range and the byte-count helper.
// Rev    : 1.0 - initial release
//==============================================================================
package dmem_pkg;

    // Controller states: clearing the array, or serving requests
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    // Supported read latency window
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Number of byte lanes in a word of the given width
    function automatic int byte_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_rd_pipe.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : dmem_rd_pipe
// Brief  : LAT-deep shift pipeline carrying {valid, err, payload} from the
//          accept edge to the output. Payload only advances alongside a valid
//          bit, so the last stage holds the most recent read result.
// Rev    : 1.0 - initial release
//==============================================================================
module dmem_rd_pipe #(
    parameter int PAY_W = 32,
    parameter int LAT   = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    input  logic             InErr,
    input  logic [PAY_W-1:0] InData,
    output logic             OutValid,
    output logic             OutErr,
    output logic [PAY_W-1:0] OutData
);

    logic [LAT-1:0]   r_valid;
    logic [LAT-1:0]   r_err;
    logic [PAY_W-1:0] r_data [LAT];

    // Shift valid/err every cycle; data stages load only when valid arrives
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_valid <= '0;
            r_err   <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= InValid;
            r_err[0]   <= InErr;
            if (InValid) begin
                r_data[0] <= InData;
            end
            for (int i = 1; i < LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_err[i]   <= r_err[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign OutValid = r_valid[LAT-1];
    assign OutErr   = r_err[LAT-1];
    assign OutData  = r_data[LAT-1];

endmodule : dmem_rd_pipe
`default_nettype wire

// File: rtl/dmem_banked.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : dmem_banked
// Brief  : Word-addressed data RAM with request/ready handshake, byte write
//          enables, RD_LAT-cycle read pipeline, power-on clear sequence and
//          out-of-range flagging.
// Config : DMEM_PARITY_EN - store an even-parity bit per byte and report
//          read-side parity failures on ParErr.
// Rev    : 1.0 - initial release
//==============================================================================
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Req,
    input  logic                We,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic [DATA_W/8-1:0] ByteEn,
    input  logic [DATA_W-1:0]   WriteData,
    output logic                Ready,
    output logic                RdValid,
    output logic [DATA_W-1:0]   ReadData,
    output logic                AddrErr,
    output logic                InitDone
`ifdef DMEM_PARITY_EN
   ,output logic                ParErr
`endif
);

    localparam int c_nb    = byte_count(DATA_W);
    localparam int c_idx_w = $clog2(DEPTH);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DEPTH - 1);
`ifdef DMEM_PARITY_EN
    localparam int c_pay_w = DATA_W + 1;
`else
    localparam int c_pay_w = DATA_W;
`endif

    // Reject unsupported latencies at elaboration time
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
        $error("dmem_banked: RD_LAT out of supported range");
    end

    logic [0:0]         r_state;
    logic [c_idx_w-1:0] r_clr_cnt;
    logic               r_init_done;
    logic               r_ready;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_accept;
    logic               w_oob;
    logic [c_idx_w-1:0] w_idx;
    logic [DATA_W-1:0]  w_rd_data;
    logic [c_pay_w-1:0] w_pay_in;
    logic [c_pay_w-1:0] w_pay_out;

    assign w_accept  = Req & r_ready;
    assign w_oob     = (Addr >= ADDR_W'(DEPTH));
    assign w_idx     = Addr[c_idx_w-1:0];
    assign w_rd_data = w_oob ? '0 : r_mem[w_idx];

    // Clear sequencer: one word per cycle, then hand over to request service
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= ST_INIT;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            // Ready trails InitDone by one cycle
            r_ready <= r_init_done;
            if (r_state == ST_INIT) begin
                if (r_clr_cnt == c_last_idx) begin
                    r_state     <= ST_IDLE;
                    r_init_done <= 1'b1;
                end else begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
            end
        end
    end

    // Array write port: clear during INIT, byte-masked writes afterwards
    always_ff @(posedge Clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_accept && We && !w_oob) begin
            for (int b = 0; b < c_nb; b++) begin
                if (ByteEn[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= WriteData[b*8 +: 8];
                end
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [c_nb-1:0] r_par [DEPTH];
    logic [c_nb-1:0] w_perr_bits;
    logic            w_perr;

    // Parity array tracks the data array; zero data carries zero parity
    always_ff @(posedge Clk) begin
        if (r_state == ST_INIT) begin
            r_par[r_clr_cnt] <= '0;
        end else if (w_accept && We && !w_oob) begin
            for (int b = 0; b < c_nb; b++) begin
                if (ByteEn[b]) begin
                    r_par[w_idx][b] <= ^WriteData[b*8 +: 8];
                end
            end
        end
    end

    // A byte fails when data plus stored parity bit has odd weight
    always_comb begin
        w_perr_bits = '0;
        for (int b = 0; b < c_nb; b++) begin
            w_perr_bits[b] = (^r_mem[w_idx][b*8 +: 8]) ^ r_par[w_idx][b];
        end
    end

    assign w_perr   = ~w_oob & (|w_perr_bits);
    assign w_pay_in = {w_perr, w_rd_data};
`else
    assign w_pay_in = w_rd_data;
`endif

    dmem_rd_pipe #(
        .PAY_W (c_pay_w),
        .LAT   (RD_LAT)
    ) u_rd_pipe (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (w_accept & ~We),
        .InErr    (w_accept & w_oob),
        .InData   (w_pay_in),
        .OutValid (RdValid),
        .OutErr   (AddrErr),
        .OutData  (w_pay_out)
    );

    assign ReadData = w_pay_out[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
    assign ParErr   = RdValid & w_pay_out[DATA_W];
`endif
    assign Ready    = r_ready;
    assign InitDone = r_init_done;

endmodule : dmem_banked
`default_nettype wire

// File: tb/tb_dmem_banked.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module : tb_dmem_banked
// Brief  : Self-checking bench for dmem_banked: array reference model with a
//          cycle-slot completion schedule, directed scenarios plus random
//          traffic.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_dmem_banked;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 12;
    localparam int RD_LAT = 3;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Req;
    logic              We;
    logic [ADDR_W-1:0] Addr;
    logic [3:0]        ByteEn;
    logic [DATA_W-1:0] WriteData;
    logic              Ready;
    logic              RdValid;
    logic [DATA_W-1:0] ReadData;
    logic              AddrErr;
    logic              InitDone;
`ifdef DMEM_PARITY_EN
    logic              ParErr;
`endif

    dmem_banked #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Req       (Req),
        .We        (We),
        .Addr      (Addr),
        .ByteEn    (ByteEn),
        .WriteData (WriteData),
        .Ready     (Ready),
        .RdValid   (RdValid),
        .ReadData  (ReadData),
        .AddrErr   (AddrErr),
        .InitDone  (InitDone)
`ifdef DMEM_PARITY_EN
       ,.ParErr    (ParErr)
`endif
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: memory contents and completions expected per edge
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                sv [8];
    bit                se [8];
    bit                sp [8];
    logic [DATA_W-1:0] sd [8];
    int                edge_n;
    logic [DATA_W-1:0] exp_rdata;
    bit                exp_ready;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 8; i++) begin
            sv[i] = 1'b0;
            se[i] = 1'b0;
            sp[i] = 1'b0;
            sd[i] = '0;
        end
    endtask

    // One cycle: present a request, advance one edge, check the outputs
    task automatic step(input bit req, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [3:0] be, input logic [DATA_W-1:0] wd, input bit perr_exp);
        int slot;
        bit oob;
        Req       = req;
        We        = we;
        Addr      = addr;
        ByteEn    = be;
        WriteData = wd;
        check_eq("ready", {63'd0, Ready}, {63'd0, exp_ready});
        if (req && exp_ready) begin
            slot = (edge_n + RD_LAT) % 8;
            oob  = (int'(addr) >= DEPTH);
            se[slot] = oob;
            if (!we) begin
                sv[slot] = 1'b1;
                sd[slot] = oob ? '0 : ref_mem[int'(addr)];
                sp[slot] = perr_exp;
            end else if (!oob) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[int'(addr)][b*8 +: 8] = wd[b*8 +: 8];
                end
            end
        end
        @(posedge Clk);
        edge_n++;
        @(negedge Clk);
        Req  = 1'b0;
        slot = edge_n % 8;
        if (sv[slot]) exp_rdata = sd[slot];
        check_eq("rdvalid", {63'd0, RdValid}, {63'd0, sv[slot]});
        check_eq("addrerr", {63'd0, AddrErr}, {63'd0, se[slot]});
        check_eq("readdata", {32'd0, ReadData}, {32'd0, exp_rdata});
`ifdef DMEM_PARITY_EN
        check_eq("parerr", {63'd0, ParErr}, {63'd0, sv[slot] & sp[slot]});
`endif
        sv[slot] = 1'b0;
        se[slot] = 1'b0;
        sp[slot] = 1'b0;
    endtask

    // Assert reset now, optionally interrupt the clear, then time the clear
    task automatic do_reset(input int interrupt_after);
        int n;
        int spurious;
        Rst = 1'b1;
        #1;
        check_eq("rst_rdvalid", {63'd0, RdValid}, 64'd0);
        check_eq("rst_addrerr", {63'd0, AddrErr}, 64'd0);
        check_eq("rst_readdata", {32'd0, ReadData}, 64'd0);
        check_eq("rst_ready", {63'd0, Ready}, 64'd0);
        check_eq("rst_initdone", {63'd0, InitDone}, 64'd0);
        clear_sched();
        exp_rdata = '0;
        exp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        if (interrupt_after > 0) begin
            repeat (interrupt_after) @(negedge Clk);
            Rst = 1'b1;
            repeat (2) @(negedge Clk);
            Rst = 1'b0;
        end
        n = 0;
        spurious = 0;
        while (!InitDone && n < 2000) begin
            // Requests during the clear must be ignored entirely
            Req       = 1'($urandom % 2);
            We        = 1'($urandom % 2);
            Addr      = ADDR_W'($urandom % 16);
            ByteEn    = 4'hF;
            WriteData = $urandom;
            @(posedge Clk);
            n++;
            @(negedge Clk);
            if (RdValid || AddrErr) spurious++;
        end
        Req = 1'b0;
        check_eq("init_cycles", 64'(n), 64'(DEPTH));
        check_eq("init_ready_lag", {63'd0, Ready}, 64'd0);
        check_eq("init_spurious", 64'(spurious), 64'd0);
        @(posedge Clk);
        @(negedge Clk);
        check_eq("ready_after_init", {63'd0, Ready}, 64'd1);
        exp_ready = 1'b1;
    endtask

    initial begin
        Rst = 1'b0; Req = 1'b0; We = 1'b0; Addr = '0; ByteEn = '0; WriteData = '0;
        edge_n = 0;
        #2;
        do_reset(100);

        // Cleared memory reads zero
        step(1, 0, 12'd5, 4'h0, 32'h0, 0);
        repeat (RD_LAT) step(0, 0, 12'd0, 4'h0, 32'h0, 0);

        // Byte-masked merge
        step(1, 1, 12'd3, 4'b1111, 32'hDEADBEEF, 0);
        step(1, 1, 12'd3, 4'b0001, 32'h000000AA, 0);
        step(1, 1, 12'd3, 4'b0000, 32'hFFFFFFFF, 0);
        step(1, 0, 12'd3, 4'h0, 32'h0, 0);
        repeat (RD_LAT) step(0, 0, 12'd0, 4'h0, 32'h0, 0);
        check_eq("merge_value", {32'd0, ReadData}, {32'd0, 32'hDEADBEAA});

        // Back-to-back reads
        step(1, 1, 12'd0, 4'hF, 32'h11, 0);
        step(1, 1, 12'd1, 4'hF, 32'h22, 0);
        step(1, 1, 12'd2, 4'hF, 32'h33, 0);
        step(1, 0, 12'd0, 4'h0, 32'h0, 0);
        step(1, 0, 12'd1, 4'h0, 32'h0, 0);
        step(1, 0, 12'd2, 4'h0, 32'h0, 0);
        repeat (RD_LAT) step(0, 0, 12'd0, 4'h0, 32'h0, 0);
        check_eq("b2b_last", {32'd0, ReadData}, 64'h33);

        // Out-of-range read and write; addr 2048 aliases index 0 in the low bits
        step(1, 0, 12'd1024, 4'h0, 32'h0, 0);
        step(1, 1, 12'd2048, 4'hF, 32'h55, 0);
        step(1, 0, 12'd0, 4'h0, 32'h0, 0);
        repeat (RD_LAT) step(0, 0, 12'd0, 4'h0, 32'h0, 0);
        check_eq("oob_no_alias", {32'd0, ReadData}, 64'h11);

        // Read directly after write
        step(1, 1, 12'd9, 4'hF, 32'hCAFEF00D, 0);
        step(1, 0, 12'd9, 4'h0, 32'h0, 0);
        repeat (RD_LAT) step(0, 0, 12'd0, 4'h0, 32'h0, 0);
        check_eq("raw_value", {32'd0, ReadData}, {32'd0, 32'hCAFEF00D});

`ifdef DMEM_PARITY_EN
        step(1, 1, 12'd7, 4'hF, 32'h12345678, 0);
        step(1, 1, 12'd8, 4'hF, 32'h0F0F0F0F, 0);
        u_dut.r_mem[7] = u_dut.r_mem[7] ^ 32'h0000_0100;
        ref_mem[7]     = ref_mem[7] ^ 32'h0000_0100;
        step(1, 0, 12'd7, 4'h0, 32'h0, 1);
        step(1, 0, 12'd8, 4'h0, 32'h0, 0);
        repeat (RD_LAT) step(0, 0, 12'd0, 4'h0, 32'h0, 0);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [ADDR_W-1:0] a;
            if ($urandom % 8 == 0) a = ADDR_W'(1024 + $urandom % 3072);
            else                   a = ADDR_W'($urandom % 16);
            step(($urandom % 4) != 0, 1'($urandom % 2), a, 4'($urandom % 16), $urandom, 0);
        end
        repeat (RD_LAT) step(0, 0, 12'd0, 4'h0, 32'h0, 0);

        // Reset with two reads in flight: they must vanish, memory re-cleared
        step(1, 0, 12'd3, 4'h0, 32'h0, 0);
        step(1, 0, 12'd9, 4'h0, 32'h0, 0);
        do_reset(0);
        step(1, 0, 12'd9, 4'h0, 32'h0, 0);
        repeat (RD_LAT) step(0, 0, 12'd0, 4'h0, 32'h0, 0);
        check_eq("recleared", {32'd0, ReadData}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dmem_banked
`default_nettype wire
